// File: rtl/pingpong_buffer_ctrl.sv
// Two-bank ping-pong buffer controller: the writer fills one bank while
// the reader drains the other over a shared dual-port memory.
module pingpong_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 640
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rq_write,
    output logic                  ack_write,
    input  logic                  writing,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rq_read,
    output logic                  ack_read,
    input  logic                  reading,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]   mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            bank_full,
    output logic                  overflow
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {W_IDLE, W_GRANT, W_ACTIVE, W_RELEASE} wst_t;
    typedef enum logic [1:0] {R_IDLE, R_GRANT, R_ACTIVE, R_RELEASE} rst_t;

    wst_t                  wst_q, wst_d;
    rst_t                  rst_q, rst_d;
    logic                  wb_q, wb_d, rb_q, rb_d;
    logic [CW-1:0]         wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0][CW-1:0]    fill_q, fill_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  ack_write_q, ack_write_d;
    logic                  ack_read_q, ack_read_d;
    logic                  overflow_q, overflow_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH:0]   mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH:0]   mem_raddr_q, mem_raddr_d;
    logic                  rv1_q, rv1_d, rl1_q, rl1_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  w_commit;
    logic [CW-1:0]         w_commit_cnt;
    logic [1:0]            full_set, full_clr;

    always_comb begin
        wst_d        = wst_q;
        rst_d        = rst_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        fill_d       = fill_q;
        ack_write_d  = ack_write_q;
        ack_read_d   = ack_read_q;
        overflow_d   = overflow_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_raddr_d  = mem_raddr_q;
        rv1_d        = 1'b0;
        rl1_d        = 1'b0;
        rd_valid_d   = rv1_q;
        rd_last_d    = rl1_q;
        w_commit     = 1'b0;
        w_commit_cnt = wcnt_q;
        full_set     = 2'b00;
        full_clr     = 2'b00;

        unique case (wst_q)
            W_IDLE: if (rq_write && !bank_full_q[wb_q]) begin
                ack_write_d = 1'b1;
                wst_d       = W_GRANT;
            end
            W_GRANT: if (writing) wst_d = W_ACTIVE;
            W_ACTIVE: begin
                if (!writing) begin
                    w_commit    = (wcnt_q != '0);
                    ack_write_d = 1'b0;
                    wst_d       = W_RELEASE;
                end else if (wr_valid) begin
                    // After an auto-commit the burst may land on a full bank
                    if (!bank_full_q[wb_q] && wcnt_q < DEPTH_C) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = {wb_q, wcnt_q[ADDR_WIDTH-1:0]};
                        mem_wdata_d = wr_data;
                        if (wcnt_q == DEPTH_C - ONE) begin
                            w_commit     = 1'b1;
                            w_commit_cnt = DEPTH_C;
                        end else begin
                            wcnt_d = wcnt_q + ONE;
                        end
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            W_RELEASE: wst_d = W_IDLE;
        endcase

        if (w_commit) begin
            fill_d[wb_q]   = w_commit_cnt;
            full_set[wb_q] = 1'b1;
            wcnt_d         = '0;
            wb_d           = ~wb_q;
        end

        unique case (rst_q)
            R_IDLE: if (rq_read && bank_full_q[rb_q]) begin
                ack_read_d = 1'b1;
                rst_d      = R_GRANT;
            end
            R_GRANT: if (reading) rst_d = R_ACTIVE;
            R_ACTIVE: begin
                if (!reading) begin
                    rcnt_d     = '0;
                    ack_read_d = 1'b0;
                    rst_d      = R_RELEASE;
                end else if (rd_en && bank_full_q[rb_q]
                             && rcnt_q < fill_q[rb_q]) begin
                    mem_raddr_d = {rb_q, rcnt_q[ADDR_WIDTH-1:0]};
                    rv1_d       = 1'b1;
                    if (rcnt_q == fill_q[rb_q] - ONE) begin
                        rl1_d          = 1'b1;
                        full_clr[rb_q] = 1'b1;
                        rb_d           = ~rb_q;
                        rcnt_d         = '0;
                    end else begin
                        rcnt_d = rcnt_q + ONE;
                    end
                end
            end
            R_RELEASE: rst_d = R_IDLE;
        endcase

        bank_full_d = (bank_full_q | full_set) & ~full_clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wst_q       <= W_IDLE;
            rst_q       <= R_IDLE;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            fill_q      <= '0;
            bank_full_q <= 2'b00;
            ack_write_q <= 1'b0;
            ack_read_q  <= 1'b0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_raddr_q <= '0;
            rv1_q       <= 1'b0;
            rl1_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            wst_q       <= wst_d;
            rst_q       <= rst_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            fill_q      <= fill_d;
            bank_full_q <= bank_full_d;
            ack_write_q <= ack_write_d;
            ack_read_q  <= ack_read_d;
            overflow_q  <= overflow_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_raddr_q <= mem_raddr_d;
            rv1_q       <= rv1_d;
            rl1_q       <= rl1_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign ack_write = ack_write_q;
    assign ack_read  = ack_read_q;
    assign overflow  = overflow_q;
    assign bank_full = bank_full_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_raddr = mem_raddr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_data   = mem_rdata;
endmodule

// File: doc/pingpong_buffer_ctrl.md
# pingpong_buffer_ctrl

Two-bank (ping-pong) frame/line buffer controller that arbitrates a single external dual-port memory between the pixel writer and the Sobel window reader. The writer side speaks the rq_write/ack_write/writing handshake; the reader side speaks the mirror-image rq_read/ack_read/reading handshake. A bank filled by the writer is committed and handed to the reader. Writer and reader operate concurrently on opposite banks.

## Interface
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, 10, per-bank address width
- DEPTH, 640, words per bank; DEPTH ≤ 2^ADDR_WIDTH
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rq_write  in  1  writer requests a bank
- ack_write  out  1  write grant, held until burst ends
- writing  in  1  writer burst active
- wr_valid  in  1  wr_data valid this cycle
- wr_data  in  DATA_WIDTH  pixel to store
- rq_read  in  1  reader requests a committed bank
- ack_read  out  1  read grant, held until burst ends
- reading  in  1  reader burst active
- rd_en  in  1  reader pops one word
- rd_data  out  DATA_WIDTH  driven directly from mem_rdata
- rd_valid  out  1  rd_data valid
- rd_last  out  1  with rd_valid, last word of bank
- mem_we  out  1  memory write strobe
- mem_waddr  out  ADDR_WIDTH+1  {bank, offset}
- mem_wdata  out  DATA_WIDTH
- mem_raddr  out  ADDR_WIDTH+1  {bank, offset}
- mem_rdata  in  DATA_WIDTH  memory read data, 1-cycle registered read
- bank_full  out  2  per-bank committed flag
- overflow  out  1  sticky: write word dropped

## Operation
- State: wb (write bank), rb (read bank), wcnt, rcnt (ADDR_WIDTH+1 bits), fill[0..1] (ADDR_WIDTH+1 bits), bank_full[1:0].
- Write FSM W_IDLE→W_GRANT→W_ACTIVE→W_RELEASE→W_IDLE.
  - W_IDLE: rq_write=1 and bank_full[wb]=0 → ack_write<=1, W_GRANT. Bank full → stay, ack_write=0.
  - W_GRANT: writing=1 → W_ACTIVE.
  - W_ACTIVE: wr_valid&writing and wcnt<DEPTH → write {wb,wcnt}, wcnt+1. wr_valid with wcnt=DEPTH → word dropped, overflow<=1.
  - Commit when wcnt reaches DEPTH, or when writing falls with wcnt>0: fill[wb]<=wcnt, bank_full[wb]<=1, wcnt<=0, wb toggles. Writing falls with wcnt=0: no commit.
  - Auto-commit mid-burst: continue into new wb only if bank_full[new wb]=0, else drop and flag overflow.
  - writing falls → W_RELEASE: ack_write<=0; next cycle W_IDLE.
- Read FSM R_IDLE→R_GRANT→R_ACTIVE→R_RELEASE→R_IDLE, mirror image.
  - Grant only when bank_full[rb]=1.
  - R_ACTIVE: rd_en&reading and rcnt<fill[rb] → mem_raddr={rb,rcnt}, rcnt+1; rd_en otherwise ignored.
  - Final word issued (rcnt=fill[rb]-1): bank_full[rb]<=0, rb toggles, rcnt<=0, rd_last with that word.
  - reading falls before final word: rcnt<=0, bank stays full; next grant re-reads from offset 0.
- Simultaneous commit and free: they always act on opposite banks; both apply the same cycle.
- rq_write and rq_read together: independent, both granted if eligible.
- overflow clears only on reset.

## Timing
- Reset (async, reset_n=0): all outputs 0, both FSMs IDLE, wb=rb=0, counters and fill 0, bank_full=00.
- ack_write/ack_read: registered, high the cycle after rq sampled with eligible bank.
- Write path: mem_we/mem_waddr/mem_wdata registered, one cycle after wr_valid sampled.
- Read path: mem_raddr registered one cycle after rd_en; rd_valid/rd_last two cycles after rd_en; rd_data = mem_rdata that cycle.
- bank_full set the cycle after the committing edge, cleared the cycle after the final read address issues.
- ack deasserts the cycle after writing/reading falls; requester's end-wait completes next cycle.

## Test plan
- DEPTH=4: write burst 4 words 0x11..0x14 → mem writes addr 0..3, bank_full=01, wb=1, ack_write drops after writing falls.
- Read bank 0 with 4 rd_en → rd_data 0x11..0x14, rd_last on 0x14, bank_full=00, rb=1.
- Partial burst of 2 words, writing falls → fill[0]=2, bank_full=01; read yields 2 words, rd_last on the second.
- Fill both banks with reader idle, then rq_write → no ack_write; words pushed into a held burst set overflow=1.
- Concurrent write to bank 1 while reading bank 0 → both complete; bank_full ends 10.
- reset_n low mid-write and mid-read → all outputs 0 immediately; post-reset rq_read is not granted.
